// File: rtl/matrix_pkg.sv
// matrix_pkg
// Shared definitions for the matrixMulti operand loader: float and matrix
// widths, the loader state encoding and the mapping from element slot to
// bit offset inside a packed 128-bit matrix bus.
package matrix_pkg;

  localparam int FP_W   = 32;
  localparam int N_ELEM = 4;
  localparam int MAT_W  = FP_W * N_ELEM;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } loader_state_t;

  // Slot 0 ([1][1]) lives in the most significant word of the bus, so the
  // row-major element order reads left to right in a hex dump.
  function automatic logic [6:0] slot_offset(input logic [1:0] slot);
    return 7'((N_ELEM - 1 - int'(slot)) * FP_W);
  endfunction

endpackage

// File: rtl/fp_denorm_flush.sv
// fp_denorm_flush
// Combinational flush-to-zero for one IEEE-754 single-precision word.
// A subnormal (exponent 0, mantissa nonzero) becomes a signed zero; every
// other encoding, including +/-0, passes through untouched.
//
// Ports:
//   word_i       32-bit float in
//   word_o       32-bit float out, subnormals replaced by {sign, 31'b0}
//   is_denorm_o  high when word_i is subnormal
module fp_denorm_flush
  import matrix_pkg::*;
(
  input  logic [FP_W-1:0] word_i,
  output logic [FP_W-1:0] word_o,
  output logic            is_denorm_o
);

  assign is_denorm_o = (word_i[30:23] == 8'd0) && (word_i[22:0] != 23'd0);
  assign word_o      = is_denorm_o ? {word_i[31], 31'b0} : word_i;

endmodule

// File: rtl/matrix_loader.sv
// matrix_loader
// Collects eight serial float words over a valid/ready handshake, packs
// them into the two 2x2 operand buses of matrixMulti, then runs a
// four-phase start/finish handshake while holding the operands stable.
// A one-cycle done pulse marks the close of each multiply cycle.
//
// Optional feature: define MATRIX_LOADER_FLUSH_DENORM_EN to flush
// subnormal input words to signed zero and report them on denorm_seen.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in_data      float word from the source
//   in_valid     in_data is valid
//   in_ready     loader can accept a word (combinational)
//   mat1         operand A, [1][1] in bits 127:96 ... [2][2] in bits 31:0
//   mat2         operand B, same layout
//   start        level request to matrixMulti
//   finish       completion from matrixMulti
//   done         one-cycle pulse when the handshake has fully closed
//   denorm_seen  sticky per-load subnormal flag (0 without the macro)
module matrix_loader #(
  parameter int FP_W   = 32,
  parameter int N_ELEM = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FP_W-1:0]        in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_ELEM*FP_W-1:0] mat1,
  output logic [N_ELEM*FP_W-1:0] mat2,
  output logic                   start,
  input  logic                   finish,
  output logic                   done,
  output logic                   denorm_seen
);

  import matrix_pkg::*;

  loader_state_t           state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [N_ELEM*FP_W-1:0]  mat1_q, mat1_d;
  logic [N_ELEM*FP_W-1:0]  mat2_q, mat2_d;
  logic                    start_q, start_d;
  logic                    done_q, done_d;
  logic                    accept;
  logic [FP_W-1:0]         store_word;

  // Reset forces in_ready low in the same cycle so a word offered during
  // reset is never treated as consumed by the source.
  assign in_ready = (state_q == LOAD) && !rst;
  assign accept   = in_valid && in_ready;

`ifdef MATRIX_LOADER_FLUSH_DENORM_EN
  logic word_is_denorm;
  logic denorm_q;

  fp_denorm_flush u_flush (
    .word_i      (in_data),
    .word_o      (store_word),
    .is_denorm_o (word_is_denorm)
  );

  // Word 0 starts a fresh load, so its own subnormal status replaces the
  // flag; later words can only set it.
  always_ff @(posedge clk) begin
    if (rst) begin
      denorm_q <= 1'b0;
    end else if (accept) begin
      denorm_q <= (cnt_q == 3'd0) ? word_is_denorm : (denorm_q | word_is_denorm);
    end
  end

  assign denorm_seen = denorm_q;
`else
  assign store_word  = in_data;
  assign denorm_seen = 1'b0;
`endif

  // Next-state logic. cnt[2] picks the matrix, cnt[1:0] the element slot;
  // only the addressed slice is rewritten, so the buses never glitch in
  // RUN or RELEASE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mat1_d  = mat1_q;
    mat2_d  = mat2_q;
    done_d  = 1'b0;

    case (state_q)
      LOAD: begin
        if (accept) begin
          if (cnt_q[2]) begin
            mat2_d[slot_offset(cnt_q[1:0]) +: FP_W] = store_word;
          end else begin
            mat1_d[slot_offset(cnt_q[1:0]) +: FP_W] = store_word;
          end
          if (cnt_q == 3'd7) begin
            cnt_d   = 3'd0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      RUN: begin
        if (finish) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!finish) begin
          state_d = LOAD;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    start_d = (state_d == RUN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= 3'd0;
      mat1_q  <= '0;
      mat2_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mat1_q  <= mat1_d;
      mat2_q  <= mat2_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign mat1  = mat1_q;
  assign mat2  = mat2_q;
  assign start = start_q;
  assign done  = done_q;

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader
// Self-checking bench for matrix_loader. The reference model keeps the
// eight loaded words as an array and packs the buses by concatenation;
// the handshake expectations follow the start/finish protocol directly.
module tb_matrix_loader;

`ifdef MATRIX_LOADER_FLUSH_DENORM_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] mat1;
  logic [127:0] mat2;
  logic         start;
  logic         finish;
  logic         done;
  logic         denorm_seen;

  int checks    = 0;
  int failures  = 0;
  int doneCount = 0;

  logic [31:0] cur [8];
  bit          expDenorm;

  matrix_loader #(.FP_W(32), .N_ELEM(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mat1        (mat1),
    .mat2        (mat2),
    .start       (start),
    .finish      (finish),
    .done        (done),
    .denorm_seen (denorm_seen)
  );

  always #5 clk = ~clk;

  // Count done pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit isSub(input logic [31:0] w);
    return (w[30:23] == 8'd0) && (w[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] modelStore(input logic [31:0] w);
    if (FlushEn && isSub(w)) return {w[31], 31'b0};
    return w;
  endfunction

  function automatic logic [127:0] expA();
    return {cur[0], cur[1], cur[2], cur[3]};
  endfunction

  function automatic logic [127:0] expB();
    return {cur[4], cur[5], cur[6], cur[7]};
  endfunction

  function automatic logic [31:0] randWord();
    case ($urandom_range(0, 4))
      0:       return {1'($urandom_range(0, 1)), 8'd0, 23'($urandom_range(1, 32'h7FFFFF))};
      1:       return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 8; i++) cur[i] = 32'h0;
    expDenorm = 1'b0;
  endtask

  // gapMode: 0 back-to-back, 1 alternating idle cycles, 2 random idles.
  // extraInRun keeps a ninth word offered through RUN and RELEASE.
  task automatic applyStimulus(input logic [31:0] w [8], input int gapMode,
                               input bit extraInRun, input logic [31:0] extraWord);
    for (int i = 0; i < 8; i++) begin
      finish = 1'b0;
      checkBit("ready_in_load", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = w[i];
      step();
      cur[i]    = modelStore(w[i]);
      expDenorm = FlushEn && ((i == 0) ? isSub(w[i]) : (expDenorm || isSub(w[i])));
      checkOutput("mat1_fill", mat1, expA());
      checkOutput("mat2_fill", mat2, expB());
      checkBit("denorm_fill", denorm_seen, expDenorm);
      if (i < 7 && (gapMode == 1 || (gapMode == 2 && $urandom_range(0, 1) == 1))) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        finish   = 1'($urandom_range(0, 1));
        step();
        checkOutput("mat1_gap", mat1, expA());
        checkBit("start_gap", start, 1'b0);
      end
    end
    finish   = 1'b0;
    in_valid = extraInRun;
    in_data  = extraWord;
    checkBit("start_run", start, 1'b1);
    checkBit("ready_run", in_ready, 1'b0);
  endtask

  task automatic runHandshake(input int finDelay, input int relDelay);
    int base;
    for (int k = 0; k < finDelay; k++) begin
      step();
      checkBit("start_hold", start, 1'b1);
      checkBit("ready_hold", in_ready, 1'b0);
      checkBit("done_run", done, 1'b0);
      checkOutput("mat1_run", mat1, expA());
      checkOutput("mat2_run", mat2, expB());
    end
    finish = 1'b1;
    step();
    checkBit("start_fall", start, 1'b0);
    checkBit("done_rel", done, 1'b0);
    checkBit("ready_rel", in_ready, 1'b0);
    checkOutput("mat1_rel", mat1, expA());
    for (int k = 1; k < relDelay; k++) begin
      step();
      checkBit("start_rel", start, 1'b0);
      checkBit("done_rel_hold", done, 1'b0);
      checkOutput("mat2_rel", mat2, expB());
    end
    finish = 1'b0;
    base   = doneCount;
    step();
    checkBit("done_pulse", done, 1'b1);
    checkBit("ready_done", in_ready, 1'b1);
    checkOutput("mat1_done", mat1, expA());
    checkOutput("mat2_done", mat2, expB());
    checkBit("denorm_done", denorm_seen, expDenorm);
    in_valid = 1'b0;
    step();
    checkBit("done_low", done, 1'b0);
    checkBit("done_once", logic'(doneCount == base + 1), 1'b1);
  endtask

  initial begin
    logic [31:0] vec  [8];
    logic [31:0] dvec [8];
    logic [31:0] rvec [8];
    int base;

    vec  = '{32'h40300000, 32'h4040A3D7, 32'h4080BC6A, 32'h41000000,
             32'h40A05A1C, 32'h3F87AE14, 32'h4134CCCC, 32'h40028F5C};
    dvec = '{32'h00000001, 32'h80000010, 32'h4080BC6A, 32'h41000000,
             32'h40A05A1C, 32'h3F87AE14, 32'h4134CCCC, 32'h40028F5C};

    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; finish = 1'b0;
    clearModel();
    $display("[TB] reset phase");
    #1;
    checkBit("ready_in_rst", in_ready, 1'b0);
    step();
    checkBit("ready_rst1", in_ready, 1'b0);
    step();
    checkOutput("mat1_rst", mat1, 128'h0);
    checkOutput("mat2_rst", mat2, 128'h0);
    checkBit("start_rst", start, 1'b0);
    checkBit("done_rst", done, 1'b0);
    checkBit("denorm_rst", denorm_seen, 1'b0);
    checkBit("ready_rst2", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    checkBit("ready_after_rst", in_ready, 1'b1);

    $display("[TB] back-to-back load");
    applyStimulus(vec, 0, 1'b0, 32'h0);
    checkOutput("mat1_b2b_const", mat1, 128'h40300000_4040A3D7_4080BC6A_41000000);
    checkOutput("mat2_b2b_const", mat2, 128'h40A05A1C_3F87AE14_4134CCCC_40028F5C);
    runHandshake(5, 2);

    $display("[TB] gapped load with extra word in RUN");
    applyStimulus(vec, 1, 1'b1, 32'hDEADBEEF);
    runHandshake(3, 2);

    $display("[TB] finish in first RUN cycle");
    applyStimulus(vec, 0, 1'b0, 32'h0);
    runHandshake(0, 1);

    $display("[TB] subnormal words");
    applyStimulus(dvec, 0, 1'b0, 32'h0);
    checkOutput("mat1_sub_word0", {96'h0, mat1[127:96]}, {96'h0, FlushEn ? 32'h00000000 : 32'h00000001});
    checkOutput("mat1_sub_word1", {96'h0, mat1[95:64]},  {96'h0, FlushEn ? 32'h80000000 : 32'h80000010});
    checkBit("denorm_set", denorm_seen, FlushEn);
    runHandshake(1, 2);
    applyStimulus(vec, 0, 1'b0, 32'h0);
    checkBit("denorm_cleared", denorm_seen, 1'b0);
    runHandshake(2, 1);

    $display("[TB] randomized loads");
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 8; i++) rvec[i] = randWord();
      applyStimulus(rvec, 2, 1'($urandom_range(0, 1)), $urandom);
      runHandshake($urandom_range(0, 6), $urandom_range(1, 4));
    end

    $display("[TB] reset during RUN");
    for (int i = 0; i < 8; i++) rvec[i] = $urandom;
    applyStimulus(rvec, 0, 1'b0, 32'h0);
    rst  = 1'b1;
    base = doneCount;
    step();
    clearModel();
    checkBit("start_rst_run", start, 1'b0);
    checkOutput("mat1_rst_run", mat1, 128'h0);
    checkOutput("mat2_rst_run", mat2, 128'h0);
    checkBit("ready_rst_run", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    checkBit("ready_rel_rst", in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      checkBit("done_after_rst", done, 1'b0);
    end
    checkBit("no_done_rst", logic'(doneCount == base), 1'b1);

    $display("[TB] reset during partial load");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    clearModel();
    checkOutput("mat1_partial_rst", mat1, 128'h0);
    rst = 1'b0;
    #1;
    applyStimulus(vec, 0, 1'b0, 32'h0);
    runHandshake(1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
